nco_gen: RTL
============

NCO_GEN -- requirements
Module: nco_gen

Interface
REQ-001 Parameters SHALL be: PHASE_W, default 24, phase accumulator width; LUT_AW, default 8, waveform address width (≥4, ≤PHASE_W); OUT_W, default 20, signed output width (≤PHASE_W).
REQ-002 Ports SHALL be:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  advance accumulator and issue one sample
- fcw_wr  in  1  load-request strobe for frequency control word
- fcw_in  in  PHASE_W  new frequency control word (FCW)
- sync_clr  in  1  synchronous phase clear
- poff  in  PHASE_W  phase offset
- mode  in  2  waveform select
- amp  in  8  amplitude scale
- fcw_busy  out  1  pending FCW not yet applied
- sine  out  OUT_W  signed sample
- out_valid  out  1  sample-valid strobe
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.

Function
REQ-004 Accumulator: on each edge with en=1, phase <= phase + fcw_act (mod 2^PHASE_W); it SHALL hold when en=0.
REQ-005 FCW load: fcw_wr=1 SHALL write fcw_in to fcw_pend and set fcw_busy at the same edge; a later fcw_wr while busy SHALL overwrite fcw_pend.
REQ-006 fcw_pend SHALL move to fcw_act at the first en=1 edge whose add carries out (wrap). It SHALL also move at any en=1 edge when fcw_act=0. fcw_busy SHALL clear at that edge. The new FCW SHALL be used from the following increment.
REQ-007 sync_clr=1 SHALL force phase to 0 and apply any pending FCW. It SHALL override en's increment, but the stage-1 capture of REQ-008 still occurs if en=1. fcw_wr in the same cycle SHALL be pended, not applied.
REQ-008 Stage 1 (edge where en=1): capture p = phase (pre-increment value) + poff (mod 2^PHASE_W), together with mode and amp. Let a = p[PHASE_W-1 -: LUT_AW].
REQ-009 Stage 2: compute the sample s per REQ-010 to REQ-012 and register it with amp.
REQ-010 Sine (mode 00) uses a quarter-wave table Q[k], k = 0..2^(LUT_AW-2)-1, Q[k] = round((2^(OUT_W-1)-1)·sin(2π(k+0.5)/2^LUT_AW)).
- Quadrant q = a[LUT_AW-1:LUT_AW-2]; index = low bits of a.
- Index SHALL be bit-inverted when q is odd.
- Result SHALL be negated when q ≥ 2.
REQ-011 Cosine (mode 01) SHALL equal mode 00 with a + 2^(LUT_AW-2).
REQ-012 Square (mode 10): s = +(2^(OUT_W-1)-1) when a MSB = 0, otherwise -(2^(OUT_W-1)-1). Sawtooth (mode 11): s = p[PHASE_W-1 -: OUT_W] read as two's complement.
REQ-013 Stage 3: sine <= (s·(amp+1)) arithmetic-shifted right 8, floor rounding. amp=255 SHALL give exact unity. No overflow is possible.
REQ-014 out_valid SHALL be en delayed by exactly 2 edges. sine SHALL update only when out_valid rises with it and SHALL otherwise hold its last value.
REQ-015 Latency SHALL be: en sampled at edge t gives sine/out_valid at edge t+2. Back-to-back en SHALL give one sample per cycle with no bubbles.
REQ-016 Changes to poff, mode or amp SHALL affect only samples whose stage-1 capture is at or after the change. In-flight samples SHALL be unaffected.

Reset
REQ-017 reset_n=0 SHALL immediately clear phase, fcw_act, fcw_pend, fcw_busy, sine, out_valid and all pipeline registers to 0, regardless of clk.
REQ-018 After reset release, en=1 with fcw_act=0 SHALL yield sine = Q[0]-based output at phase 0 (mode 00) until an FCW is applied.
REQ-019 Reset asserted mid-stream SHALL discard all in-flight samples. The first out_valid after release SHALL come no earlier than 2 edges after the first en=1 edge.

Verification
REQ-020 Reset, then fcw_wr with fcw_in=2^16 and continuous en, mode 00, amp 255, poff 0:
- fcw applies on the first en edge.
- First valid sine = 6434.
- sample[n+128] = -sample[n].
- Period = 256 samples.
REQ-021 Mode 10, amp 255: 128 samples of +524287, then 128 of -524287. With amp 127: +262143 and -262144.
REQ-022 Mode 11, fcw=2^16: successive samples step by +4096 and wrap from 520192 to -524288.
REQ-023 fcw_wr(2^17) issued mid-period at fcw=2^16:
- fcw_busy stays 1 until the wrap edge.
- The sample spacing doubles only after the wrap.
- The phase stays continuous.
REQ-024 Toggle en 1-0-1 and pulse sync_clr mid-stream. out_valid SHALL track en delayed by 2 edges, and the sample after sync_clr SHALL correspond to phase 0. Assert reset_n low between edges: outputs SHALL read 0 immediately.

Source files
------------

// File: rtl/nco_gen.sv
// Purpose: phase-accumulator NCO with sine, cosine, square and sawtooth outputs and 8-bit amplitude scaling.
// Latency: en sampled at edge t -> sine/out_valid at edge t+2; back-to-back en gives one sample per cycle.
// Backpressure: none (free-running); FCW writes are held pending and applied at a phase wrap or sync_clr.
module nco_gen #(
    parameter int PHASE_W = 24,
    parameter int LUT_AW  = 8,
    parameter int OUT_W   = 20
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     en,
    input  logic                     fcw_wr,
    input  logic [PHASE_W-1:0]       fcw_in,
    input  logic                     sync_clr,
    input  logic [PHASE_W-1:0]       poff,
    input  logic [1:0]               mode,
    input  logic [7:0]               amp,
    output logic                     fcw_busy,
    output logic signed [OUT_W-1:0]  sine,
    output logic                     out_valid
);
    localparam int QW = LUT_AW - 2;
    localparam int QN = 2**QW;
    // Only the top bits of the offset phase are ever looked at downstream.
    localparam int PW = (OUT_W > LUT_AW) ? OUT_W : LUT_AW;
    localparam logic signed [OUT_W-1:0] FULL = {1'b0, {(OUT_W-1){1'b1}}};

    // Quarter-wave entry k, sampled at bin centres so the table folds symmetrically.
    function automatic logic [OUT_W-1:0] q_val(input int k);
        real ang;
        real v;
        ang = 2.0 * 3.14159265358979323846 * (real'(k) + 0.5) / real'(2**LUT_AW);
        v   = $sin(ang) * (2.0**(OUT_W-1) - 1.0);
        return OUT_W'($rtoi(v + 0.5));
    endfunction

    logic [OUT_W-1:0] w_qtab [QN];
    for (genvar gk = 0; gk < QN; gk++) begin : g_qtab
        assign w_qtab[gk] = q_val(gk);
    end

    logic [PHASE_W-1:0]       r_phase;
    logic [PHASE_W-1:0]       r_fcw_act;
    logic [PHASE_W-1:0]       r_fcw_pend;
    logic                     r_fcw_busy;
    logic [PW-1:0]            r_s1_p;
    logic [1:0]               r_s1_mode;
    logic [7:0]               r_s1_amp;
    logic                     r_s1_vld;
    logic signed [OUT_W-1:0]  r_s2_s;
    logic [7:0]               r_s2_amp;
    logic                     r_s2_vld;

    logic [PHASE_W:0]         w_sum;
    logic                     w_fcw_apply;
    logic [LUT_AW-1:0]        w_addr;
    logic [LUT_AW-1:0]        w_trig_a;
    logic [QW-1:0]            w_idx;
    logic [OUT_W-1:0]         w_mag;
    logic signed [OUT_W-1:0]  w_s;
    logic signed [OUT_W+9:0]  w_s_ext;
    logic signed [OUT_W+9:0]  w_g_ext;
    logic signed [OUT_W+9:0]  w_prod;

    assign fcw_busy = r_fcw_busy;

    // Next-phase sum and the decision to promote the pending FCW (wrap, idle accumulator, or clear).
    always_comb begin
        w_sum       = {1'b0, r_phase} + {1'b0, r_fcw_act};
        w_fcw_apply = r_fcw_busy & (sync_clr | (en & (w_sum[PHASE_W] | (r_fcw_act == '0))));
    end

    // Phase accumulator and FCW pending/active registers; a write in the same cycle as a promotion stays pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase    <= '0;
            r_fcw_act  <= '0;
            r_fcw_pend <= '0;
            r_fcw_busy <= 1'b0;
        end else begin
            if (sync_clr) begin
                r_phase <= '0;
            end else if (en) begin
                r_phase <= w_sum[PHASE_W-1:0];
            end
            if (w_fcw_apply) begin
                r_fcw_act <= r_fcw_pend;
            end
            if (fcw_wr) begin
                r_fcw_pend <= fcw_in;
                r_fcw_busy <= 1'b1;
            end else if (w_fcw_apply) begin
                r_fcw_busy <= 1'b0;
            end
        end
    end

    // Stage 1: capture offset phase (pre-increment) with the waveform controls that belong to this sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_p    <= '0;
            r_s1_mode <= '0;
            r_s1_amp  <= '0;
            r_s1_vld  <= 1'b0;
        end else begin
            r_s1_vld <= en;
            if (en) begin
                r_s1_p    <= PW'((r_phase + poff) >> (PHASE_W - PW));
                r_s1_mode <= mode;
                r_s1_amp  <= amp;
            end
        end
    end

    // Waveform generation: quarter-wave fold for sine/cosine, sign of MSB for square, raw phase for saw.
    always_comb begin
        w_addr   = r_s1_p[PW-1 -: LUT_AW];
        w_trig_a = w_addr;
        if (r_s1_mode == 2'b01) begin
            w_trig_a = w_addr + LUT_AW'(QN);
        end
        w_idx = w_trig_a[QW-1:0] ^ {QW{w_trig_a[LUT_AW-2]}};
        w_mag = w_qtab[w_idx];
        case (r_s1_mode)
            2'b00, 2'b01: w_s = w_trig_a[LUT_AW-1] ? -$signed(w_mag) : $signed(w_mag);
            2'b10:        w_s = w_addr[LUT_AW-1] ? -FULL : FULL;
            default:      w_s = $signed(r_s1_p[PW-1 -: OUT_W]);
        endcase
    end

    // Stage 2: register the raw sample together with its amplitude.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_s   <= '0;
            r_s2_amp <= '0;
            r_s2_vld <= 1'b0;
        end else begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_s   <= w_s;
                r_s2_amp <= r_s1_amp;
            end
        end
    end

    // Amplitude scaling by (amp+1)/256; amp=255 is exact unity and the shift floors.
    always_comb begin
        w_s_ext = (OUT_W+10)'(r_s2_s);
        w_g_ext = (OUT_W+10)'({2'b00, r_s2_amp} + 10'd1);
        w_prod  = w_s_ext * w_g_ext;
    end

    // Stage 3: output register; sine only moves when a valid sample lands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sine      <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= r_s2_vld;
            if (r_s2_vld) begin
                sine <= OUT_W'(w_prod >>> 8);
            end
        end
    end
endmodule
